hilo_mdu_ctrl: RTL and testbench

- Sequencer for the shared multiply/divide datapath and the HI/LO register pair.
- Sits beside EX. Accepts mult/multu/div/divu/mthi/mtlo requests from EX and runs a 32-iteration radix-2 shift-add multiply or restoring divide.
- Raises stallreq to the pipeline stall controller while busy, then commits results to HI/LO.
- HI/LO values feed mfhi/mflo.

---
 rtl/hilo_mdu_ctrl.sv | 169 ++++++++++++++++
 tb/tb_hilo_mdu_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/hilo_mdu_ctrl.sv
// rtl/hilo_mdu_ctrl.sv - multiply/divide sequencer and HI/LO register pair
module hilo_mdu_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        start,
  input  logic [5:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        stallreq,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        done
);

  localparam int ITER = 32;
  localparam int CW   = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [63:0]   acc;        // multiply: {partial product, multiplier}; divide: {remainder, quotient}
  logic [31:0]   opnd;       // multiplicand magnitude or divisor magnitude
  logic [31:0]   raw_a;      // unmodified dividend, returned as HI on divide by zero
  logic          is_div;
  logic          neg_q;      // product / quotient must be negated
  logic          neg_r;      // remainder must be negated
  logic          div_zero;

  logic          op_mul, op_div, op_mthi, op_mtlo, is_signed, accept;
  logic [31:0]   mag_a, mag_b;
  logic [32:0]   mul_sum;
  logic [32:0]   div_top;
  logic          div_ge;
  logic [31:0]   div_diff;
  logic [63:0]   mul_res;
  logic [31:0]   hi_res, lo_res;

  // Decode a request; only a single set op bit in IDLE without flush is honoured
  always_comb begin
    op_mul    = 1'b0;
    op_div    = 1'b0;
    op_mthi   = 1'b0;
    op_mtlo   = 1'b0;
    is_signed = 1'b0;
    if (state == IDLE && start && !flush) begin
      case (op)
        6'b000001: begin op_mul = 1'b1; is_signed = 1'b1; end
        6'b000010: op_mul  = 1'b1;
        6'b000100: begin op_div = 1'b1; is_signed = 1'b1; end
        6'b001000: op_div  = 1'b1;
        6'b010000: op_mthi = 1'b1;
        6'b100000: op_mtlo = 1'b1;
        default:   ;
      endcase
    end
  end

  assign accept = op_mul | op_div;
  // Two's-complement negation of 0x80000000 wraps to itself, which is the correct unsigned magnitude
  assign mag_a  = (is_signed && src1[31]) ? (32'd0 - src1) : src1;
  assign mag_b  = (is_signed && src2[31]) ? (32'd0 - src2) : src2;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and handshake outputs
  always_comb begin
    state_nxt = state;
    stallreq  = 1'b0;
    busy      = (state != IDLE);
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stallreq  = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        stallreq = 1'b1;
        if (flush)                          state_nxt = IDLE;
        else if (cnt == CW'(ITER - 1))      state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One iteration of shift-add multiply and restoring divide
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    div_top  = acc[63:31];
    // A set top bit means the shifted remainder already exceeds any 32-bit divisor
    div_ge   = div_top[32] | (div_top[31:0] >= opnd);
    div_diff = div_top[31:0] - opnd;
  end

  // Operand latch in cycle 0, then one iteration per CALC cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      raw_a    <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else if (accept) begin
      cnt      <= '0;
      is_div   <= op_div;
      raw_a    <= src1;
      div_zero <= op_div && (src2 == 32'd0);
      neg_q    <= is_signed && (src1[31] ^ src2[31]);
      neg_r    <= is_signed && src1[31];
      if (op_mul) begin
        acc  <= {32'd0, mag_b};
        opnd <= mag_a;
      end else begin
        acc  <= {32'd0, mag_a};
        opnd <= mag_b;
      end
    end else if (state == CALC) begin
      cnt <= cnt + 1'b1;
      if (is_div) acc <= div_ge ? {div_diff, acc[30:0], 1'b1} : {acc[62:0], 1'b0};
      else        acc <= {mul_sum, acc[31:1]};
    end
  end

  // Sign fixup of the finished magnitude result
  always_comb begin
    mul_res = neg_q ? (64'd0 - acc) : acc;
    hi_res  = mul_res[63:32];
    lo_res  = mul_res[31:0];
    if (is_div) begin
      if (div_zero) begin
        hi_res = raw_a;
        lo_res = 32'hFFFF_FFFF;
      end else begin
        hi_res = neg_r ? (32'd0 - acc[63:32]) : acc[63:32];
        lo_res = neg_q ? (32'd0 - acc[31:0])  : acc[31:0];
      end
    end
  end

  // HI/LO registers: commit in DONE unless flushed, or direct mthi/mtlo write
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (state == DONE && !flush) begin
      hi <= hi_res;
      lo <= lo_res;
    end else begin
      if (op_mthi) hi <= src1;
      if (op_mtlo) lo <= src1;
    end
  end

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// tb/tb_hilo_mdu_ctrl.sv - directed self-checking bench for hilo_mdu_ctrl
module tb_hilo_mdu_ctrl;

  localparam logic [5:0] OP_MULT  = 6'b000001;
  localparam logic [5:0] OP_MULTU = 6'b000010;
  localparam logic [5:0] OP_DIV   = 6'b000100;
  localparam logic [5:0] OP_DIVU  = 6'b001000;
  localparam logic [5:0] OP_MTHI  = 6'b010000;
  localparam logic [5:0] OP_MTLO  = 6'b100000;

  logic        clk, rst, flush, start;
  logic [5:0]  op;
  logic [31:0] src1, src2;
  logic        stallreq, busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] cur_hi, cur_lo;

  hilo_mdu_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .start    (start),
    .op       (op),
    .src1     (src1),
    .src2     (src2),
    .stallreq (stallreq),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report a mismatch
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Launch one mdu op in cycle 0 and observe cycles 0..35
  task automatic run_op(input string tag, input logic [5:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit keep,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int stall_cnt, done_cnt, done_at;
    stall_cnt = 0; done_cnt = 0; done_at = -1;
    @(posedge clk); #1;
    start = 1'b1; op = o; src1 = a; src2 = b;
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      if (stallreq) stall_cnt++;
      if (done) begin done_cnt++; if (done_at < 0) done_at = k; end
      if (k == 0)  check({tag, " stall_c0"}, {63'd0, stallreq}, 64'd1);
      if (k == 33) check({tag, " hilo_in_done"}, {hi, lo}, {cur_hi, cur_lo});
      if (k == 34) begin
        check({tag, " busy_c34"}, {63'd0, busy}, 64'd0);
        check({tag, " hilo_c34"}, {hi, lo}, {exp_hi, exp_lo});
      end
      @(posedge clk); #1;
      if ((k == 0 && !keep) || k == 33) start = 1'b0;
      // src changes during CALC must not matter
      if (k == 2) begin src1 = 32'h5A5A_1234; src2 = 32'h0000_0003; end
    end
    check({tag, " stall_cycles"}, 64'(stall_cnt), 64'd33);
    check({tag, " done_count"},   64'(done_cnt),  64'd1);
    check({tag, " done_cycle"},   64'(done_at),   64'd33);
    cur_hi = exp_hi;
    cur_lo = exp_lo;
  endtask

  // Start divu 100/7 and abort it at cycle 10 with flush or reset
  task automatic abort_op(input bit use_rst);
    @(posedge clk); #1;
    start = 1'b1; op = OP_DIVU; src1 = 32'd100; src2 = 32'd7;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 1) start = 1'b0;
      if (k == 10) begin
        if (use_rst) rst = 1'b1;
        else         flush = 1'b1;
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0;
    if (use_rst) begin cur_hi = '0; cur_lo = '0; end
    @(negedge clk);
    check(use_rst ? "rst busy" : "flush busy", {63'd0, busy}, 64'd0);
    check(use_rst ? "rst stall" : "flush stall", {63'd0, stallreq}, 64'd0);
    check(use_rst ? "rst hilo" : "flush hilo", {hi, lo}, {cur_hi, cur_lo});
    repeat (30) @(negedge clk);
    check(use_rst ? "rst hilo_late" : "flush hilo_late", {hi, lo}, {cur_hi, cur_lo});
    check(use_rst ? "rst done_late" : "flush done_late", {63'd0, done}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; start = 1'b0; op = '0; src1 = '0; src2 = '0;
    cur_hi = '0; cur_lo = '0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("reset hilo", {hi, lo}, 64'd0);
    check("reset flags", {61'd0, stallreq, busy, done}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_op("mult",       OP_MULT,  32'hFFFF_FFFD, 32'd5,        1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("multu",      OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div",        OP_DIV,   32'hFFFF_FFF9, 32'd2,        1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu",       OP_DIVU,  32'd100,       32'd7,        1'b0, 32'd2,         32'd14);
    run_op("div0",       OP_DIV,   32'h1234_5678, 32'd0,        1'b0, 32'h1234_5678, 32'hFFFF_FFFF);
    run_op("divu_zero",  OP_DIVU,  32'h8765_4321, 32'd0,        1'b0, 32'h8765_4321, 32'hFFFF_FFFF);
    run_op("div_corner", OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0,         32'h8000_0000);

    // mthi then mtlo: one cycle each, never stalls
    @(posedge clk); #1;
    start = 1'b1; op = OP_MTHI; src1 = 32'hAAAA_5555;
    @(negedge clk);
    check("mthi stall", {63'd0, stallreq}, 64'd0);
    @(posedge clk); #1;
    op = OP_MTLO; src1 = 32'h0000_1234;
    @(negedge clk);
    check("mthi hi", {32'd0, hi}, {32'd0, 32'hAAAA_5555});
    check("mtlo stall", {63'd0, stallreq}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("mtlo lo", {hi, lo}, {32'hAAAA_5555, 32'h0000_1234});
    cur_hi = 32'hAAAA_5555; cur_lo = 32'h0000_1234;

    // flush in IDLE suppresses mthi
    @(posedge clk); #1;
    start = 1'b1; op = OP_MTHI; src1 = 32'hDEAD_BEEF; flush = 1'b1;
    @(negedge clk);
    check("idle_flush stall", {63'd0, stallreq}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("idle_flush hi", {hi, lo}, {cur_hi, cur_lo});

    // more than one op bit is ignored
    @(posedge clk); #1;
    start = 1'b1; op = 6'b000011; src1 = 32'd3; src2 = 32'd4;
    @(negedge clk);
    check("multibit stall", {63'd0, stallreq}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("multibit busy", {63'd0, busy}, 64'd0);

    abort_op(1'b0);
    abort_op(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
